// File: rtl/rvv_pkg.sv
// Shared definitions for the vector instruction issue path: opcode fields,
// configuration-instruction detection and the serialisation FSM states.
package rvv_pkg;

  localparam logic [6:0] OPC_VECTOR = 7'b1010111;
  localparam logic [2:0] FUNCT3_CFG = 3'b111;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    ISSUE_CFG,
    HOLD
  } rvv_state_e;

  // vsetvli / vsetivli / vsetvl share the vector opcode with funct3 = 111.
  function automatic logic is_cfg_insn(input logic [14:0] insn);
    return (insn[6:0] == OPC_VECTOR) && (insn[14:12] == FUNCT3_CFG);
  endfunction

endpackage

// File: rtl/rvv_sync_fifo.sv
// Synchronous FIFO with registered count/empty/full; a push is refused when
// full even if a pop happens in the same cycle. Head reads as 0 when empty.
module rvv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             empty_q;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty_q ? '0 : mem[rd_ptr];
  assign count = cnt;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/rvv_insn_queue.sv
// Vector instruction issue queue: in-order FIFO plus an FSM that holds
// configuration instructions until the vector pipeline is idle.
// Optional same-cycle bypass on an empty queue: RVV_INSN_QUEUE_BYPASS_EN.
module rvv_insn_queue
  import rvv_pkg::*;
#(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [INSN_WIDTH-1:0] in_insn,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [INSN_WIDTH-1:0] out_insn,
  input  logic                  out_ready,
  input  logic                  rvv_idle,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  rvv_state_e            state;
  rvv_state_e            state_nxt;
  logic [INSN_WIDTH-1:0] head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  head_cfg;
  logic                  queue_valid;
  logic                  bypass;
  logic                  fifo_push;
  logic                  fifo_pop;

  assign head_cfg = !fifo_empty && is_cfg_insn(head[14:0]);

`ifdef RVV_INSN_QUEUE_BYPASS_EN
  assign bypass = fifo_empty && (state == RUN) && in_valid && out_ready &&
                  !is_cfg_insn(in_insn[14:0]);
`else
  assign bypass = 1'b0;
`endif

  // HOLD adds one dead cycle after a config issue so a lagging idle flag
  // cannot let the next instruction slip past the configuration change.
  always_comb begin
    state_nxt   = state;
    queue_valid = 1'b0;
    case (state)
      RUN: begin
        queue_valid = !fifo_empty && !head_cfg;
        if (head_cfg) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rvv_idle) state_nxt = ISSUE_CFG;
      end
      ISSUE_CFG: begin
        queue_valid = 1'b1;
        if (out_ready) state_nxt = HOLD;
      end
      HOLD: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  assign fifo_push = in_valid && !fifo_full && !bypass;
  assign fifo_pop  = queue_valid && out_ready;

  rvv_sync_fifo #(
    .WIDTH (INSN_WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (in_insn),
    .pop   (fifo_pop),
    .rdata (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign in_ready  = !fifo_full;
  assign out_valid = queue_valid || bypass;
  assign out_insn  = bypass ? in_insn : head;
  assign empty     = fifo_empty;
  assign full      = fifo_full;

endmodule
